ceespu_dmem_arbiter: RTL
========================

Name: ceespu_dmem_arbiter

Overview:
Shares the single data-RAM port between the ceespu data interface (dmem_e/dmem_we/dmem_addr/dmem_wdata, with busy) and a secondary host master (boot loader / DMA).
- The CPU has default priority.
- A wait counter guarantees host forward progress.
- A one-deep read-owner pipeline steers the RAM's 1-cycle-latency read data to the correct master.
- Sits between the ceespu core, the host and the data block RAM.

Parameters:
AW, 14, RAM word-address width (RAM depth 2^AW 32-bit words)
HOST_WAIT_MAX, 4, max consecutive cycles a pending host request may lose to the CPU before it is forced through (1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cpu_e  in  1  CPU data access request
cpu_we  in  4  CPU byte write enables (0 = read)
cpu_addr  in  16  CPU byte address
cpu_wdata  in  32  CPU write data
cpu_busy  out  1  CPU request not accepted this cycle; CPU holds request
cpu_rdata  out  32  CPU read data, valid cycle after accepted read
h_req  in  1  host request, held stable until h_gnt
h_we  in  4  host byte write enables (0 = read)
h_addr  in  16  host byte address
h_wdata  in  32  host write data
h_gnt  out  1  host request accepted this cycle
h_rvalid  out  1  host read data valid
h_rdata  out  32  host read data
ram_en  out  1  RAM port enable
ram_we  out  4  RAM byte write enables
ram_addr  out  AW  RAM word address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, 1-cycle latency after ram_en

Behaviour:
- Grant decision is combinational, made every cycle from registered state plus current requests:
  - host_force = (wait_cnt >= HOST_WAIT_MAX) and h_req.
  - grant_host = h_req and (not cpu_e or host_force).
  - grant_cpu = cpu_e and not grant_host.
- Port assignments:
  - cpu_busy = cpu_e and not grant_cpu.
  - h_gnt = grant_host.
  - ram_en = grant_cpu or grant_host; ram_* driven from the granted master; word address = addr[AW+1:2]; addr[1:0] ignored.
  - With no grant: ram_we=0 and ram_addr/ram_wdata=0.
- wait_cnt (4-bit register):
  - Increments when h_req and not grant_host.
  - Cleared on grant_host or when h_req is low.
  - Saturates at 15.
- Read-owner register rd_own (2 bits: NONE/CPU/HOST):
  - Next = CPU if grant_cpu and cpu_we==0.
  - Next = HOST if grant_host and h_we==0.
  - Otherwise NONE.
- Read-data steering:
  - h_rvalid = (rd_own==HOST).
  - h_rdata = ram_rdata when rd_own==HOST, else 0.
  - cpu_rdata = ram_rdata when rd_own==CPU, else holds its last captured value (registered capture, so the CPU may sample late while busy).
- Latency:
  - A write completes in its grant cycle.
  - Read data appears exactly 1 cycle after grant for both masters.
- Back-to-back grants to alternating masters are legal; rd_own pipelining keeps returns ordered.
- Simultaneous requests with wait_cnt < HOST_WAIT_MAX: CPU wins; host waits. Exactly at threshold: host wins; cpu_busy=1 for that cycle.
- Partial writes (cpu_we e.g. 4'b0011) pass through unchanged; no read-modify-write in this block.
- Reset (any cycle, including mid-transaction):
  - wait_cnt=0, rd_own=NONE, cpu_rdata=0.
  - While rst is high: no grants (ram_en=0, h_gnt=0, h_rvalid=0), cpu_busy=cpu_e.
  - Read data for an access granted in the cycle before rst asserted is discarded.
- Out-of-range addresses: upper bits above AW+1 ignored (aliasing); no error signalled.

Test Plan:
- CPU-only read: preload RAM word 5 = 32'hDEADBEEF; cpu_e=1, cpu_we=0, cpu_addr=16'h0014 -> cpu_busy=0, ram_addr=5 same cycle; cpu_rdata=32'hDEADBEEF next cycle; h_rvalid=0.
- Host-only write then read: h_req write h_addr=16'h0008, h_we=4'hF, h_wdata=32'h12345678 -> h_gnt=1 same cycle. Read back the same address -> h_gnt=1, then h_rvalid=1 with h_rdata=32'h12345678 one cycle later.
- Contention/starvation (HOST_WAIT_MAX=4): cpu_e=1 continuously, h_req=1 from cycle 0:
  - cpu granted cycles 0-3, cpu_busy=0.
  - Cycle 4: h_gnt=1, cpu_busy=1.
  - Cycle 5: CPU granted again, wait_cnt=0.
- Interleaved reads: CPU read word 1 (=32'hA) at cycle n, host read word 2 (=32'hB) forced at n+1 -> cpu_rdata=32'hA at n+1; h_rvalid=1, h_rdata=32'hB at n+2; no cross-delivery.
- Byte write: CPU write cpu_we=4'b0100, cpu_wdata=32'h00AB0000 to word 3 (initially 0) -> ram_we=4'b0100; subsequent read returns 32'h00AB0000.
- Reset mid-read: grant CPU read at cycle n, rst=1 at n+1 -> rd_own cleared, cpu_rdata=0, ram_en=0, h_gnt=0 while rst high; cpu_busy follows cpu_e; normal arbitration resumes the cycle after rst falls.

Source files
------------

// File: rtl/ceespu_dmem_arbiter_if.sv
// ceespu_dmem_arbiter_if
// Bundles the three sides of the data-RAM arbiter into one interface:
//   cpu_*  : ceespu data port (cpu_e/cpu_we/cpu_addr/cpu_wdata in, cpu_busy/cpu_rdata out)
//   h_*    : host master (h_req/h_we/h_addr/h_wdata in, h_gnt/h_rvalid/h_rdata out)
//   ram_*  : single block-RAM port (ram_en/ram_we/ram_addr/ram_wdata out, ram_rdata in)
// Modports:
//   slave  : the arbiter's view (receives requests, drives grants and the RAM port)
//   master : the surrounding system's view (CPU, host and RAM model)
interface ceespu_dmem_arbiter_if #(
    parameter int AW = 14
);
    logic          cpu_e;
    logic [3:0]    cpu_we;
    logic [15:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_busy;
    logic [31:0]   cpu_rdata;

    logic          h_req;
    logic [3:0]    h_we;
    logic [15:0]   h_addr;
    logic [31:0]   h_wdata;
    logic          h_gnt;
    logic          h_rvalid;
    logic [31:0]   h_rdata;

    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    modport slave (
        input  cpu_e, cpu_we, cpu_addr, cpu_wdata,
        output cpu_busy, cpu_rdata,
        input  h_req, h_we, h_addr, h_wdata,
        output h_gnt, h_rvalid, h_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_e, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_busy, cpu_rdata,
        output h_req, h_we, h_addr, h_wdata,
        input  h_gnt, h_rvalid, h_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/ceespu_dmem_arbiter.sv
// ceespu_dmem_arbiter
// Shares one data block-RAM port between the ceespu core (default priority)
// and a host master (boot loader / DMA). A wait counter forces a starved host
// request through after HOST_WAIT_MAX lost cycles, and a one-deep read-owner
// register steers the RAM's 1-cycle-latency read data back to whichever
// master issued the read.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : ceespu_dmem_arbiter_if.slave (CPU, host and RAM signal groups)
// Parameters:
//   AW            : RAM word-address width
//   HOST_WAIT_MAX : lost cycles after which a pending host request wins (1..15)
module ceespu_dmem_arbiter #(
    parameter int AW            = 14,
    parameter int HOST_WAIT_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    ceespu_dmem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } own_t;

    localparam logic [3:0] WAIT_MAX = 4'(HOST_WAIT_MAX);

    own_t        rd_own;
    own_t        rd_own_next;
    logic [3:0]  wait_cnt;
    logic [31:0] cpu_rdata_q;
    logic        host_force;
    logic        grant_host;
    logic        grant_cpu;

    // Low address bits select bytes within a word and are handled by the
    // byte enables; bits above AW+1 alias. Collected here so they are
    // visibly consumed.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{bus.cpu_addr, bus.h_addr};

    // Grant decision: the CPU wins ties unless the host has waited long
    // enough. Reset suppresses every grant in the same cycle.
    always_comb begin
        host_force = (wait_cnt >= WAIT_MAX) && bus.h_req;
        grant_host = !rst && bus.h_req && (!bus.cpu_e || host_force);
        grant_cpu  = !rst && bus.cpu_e && !grant_host;
    end

    // Counts consecutive cycles a pending host request has lost; saturates
    // so a tiny HOST_WAIT_MAX never wraps back below the threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (!bus.h_req || grant_host) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != 4'hF) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Read-owner state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_own <= OWN_NONE;
        end else begin
            rd_own <= rd_own_next;
        end
    end

    // Read-owner next state: remember who issued a read this cycle so the
    // returning data next cycle goes to the right master.
    always_comb begin
        rd_own_next = OWN_NONE;
        if (grant_cpu && (bus.cpu_we == 4'd0)) begin
            rd_own_next = OWN_CPU;
        end else if (grant_host && (bus.h_we == 4'd0)) begin
            rd_own_next = OWN_HOST;
        end
    end

    // Holds the last CPU read word so a stalled CPU can sample it late.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_q <= 32'd0;
        end else if (rd_own == OWN_CPU) begin
            cpu_rdata_q <= bus.ram_rdata;
        end
    end

    // Output decode: RAM port muxing and read-data steering. Read returns
    // are masked while rst is high so data from a read granted just before
    // reset is discarded.
    always_comb begin
        bus.cpu_busy  = bus.cpu_e && !grant_cpu;
        bus.h_gnt     = grant_host;
        bus.ram_en    = grant_cpu || grant_host;
        bus.ram_we    = 4'd0;
        bus.ram_addr  = '0;
        bus.ram_wdata = 32'd0;
        if (grant_host) begin
            bus.ram_we    = bus.h_we;
            bus.ram_addr  = bus.h_addr[AW+1:2];
            bus.ram_wdata = bus.h_wdata;
        end else if (grant_cpu) begin
            bus.ram_we    = bus.cpu_we;
            bus.ram_addr  = bus.cpu_addr[AW+1:2];
            bus.ram_wdata = bus.cpu_wdata;
        end

        bus.h_rvalid = !rst && (rd_own == OWN_HOST);
        bus.h_rdata  = bus.h_rvalid ? bus.ram_rdata : 32'd0;

        if (rst) begin
            bus.cpu_rdata = 32'd0;
        end else if (rd_own == OWN_CPU) begin
            bus.cpu_rdata = bus.ram_rdata;
        end else begin
            bus.cpu_rdata = cpu_rdata_q;
        end
    end

endmodule
